// File: rtl/scd_pkg.sv
// Shared constants, FSM encoding and the convolutional encoder tap function for the
// signal channel decoder.
package scd_pkg;

    localparam int unsigned N_INFO  = 32;
    localparam int unsigned N_CODED = 96;
    localparam int unsigned N_REP   = 10;
    localparam int unsigned N_STATE = 64;

    localparam logic [5:0] G0 = 6'b011011;
    localparam logic [5:0] G1 = 6'b111001;
    localparam logic [5:0] G2 = 6'b110101;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StAcs,
        StTrace,
        StOutput
    } state_e;

    // Coded triple for input d from state s; bit 0 is c0.
    function automatic logic [2:0] conv_out(input logic d, input logic [5:0] s);
        return {d ^ (^(s & G2)), d ^ (^(s & G1)), d ^ (^(s & G0))};
    endfunction

endpackage

// File: rtl/scd_if.sv
// Sample-in / bit-out bundle of the signal channel decoder. The ports 'do'/'do_vld' are
// named dout/dout_vld because 'do' is a reserved word.
interface scd_if;
    logic di;
    logic di_vld;
    logic dout;
    logic dout_vld;
    logic busy;
    logic err;

    modport master (output di, output di_vld, input dout, input dout_vld, input busy, input err);
    modport slave  (input di, input di_vld, output dout, output dout_vld, output busy, output err);
endinterface

// File: rtl/scd_acs.sv
// Branch metric plus compare-select for one next state of the 64-state trellis.
module scd_acs
    import scd_pkg::*;
#(
    parameter int unsigned PMW = 10
) (
    input  logic [PMW-1:0] pm0,
    input  logic [PMW-1:0] pm1,
    input  logic [3:0]     cnt0,
    input  logic [3:0]     cnt1,
    input  logic [3:0]     cnt2,
    input  logic [5:0]     ns,
    output logic [PMW-1:0] pm_new,
    output logic           dec
);

    logic [2:0]     e0, e1;
    logic [PMW-1:0] m0, m1;

    // Distance between an expected bit and a vote count of ones out of N_REP.
    function automatic logic [4:0] bit_metric(input logic e, input logic [3:0] c);
        return {1'b0, (e ? 4'(N_REP) - c : c)};
    endfunction

    always_comb begin
        e0 = conv_out(ns[5], {ns[4:0], 1'b0});
        e1 = conv_out(ns[5], {ns[4:0], 1'b1});
        m0 = pm0 + PMW'(bit_metric(e0[0], cnt0) + bit_metric(e0[1], cnt1)
                        + bit_metric(e0[2], cnt2));
        m1 = pm1 + PMW'(bit_metric(e1[0], cnt0) + bit_metric(e1[1], cnt1)
                        + bit_metric(e1[2], cnt2));
        dec    = m1 < m0;
        pm_new = dec ? m1 : m0;
    end

endmodule

// File: rtl/scd.sv
// Signal channel decoder: vote-combines 10 repetitions of a 96-bit coded segment, runs a
// serial two-wrap tail-biting Viterbi and shifts out the 32 recovered bits.
module scd
    import scd_pkg::*;
#(
    parameter int unsigned PMW = 10
) (
    input logic   clk,
    input logic   rst_n,
    scd_if.slave  bus
);

    state_e              state_q, state_d;
    logic [6:0]          k_q;
    logic [3:0]          rep_q;
    logic [5:0]          t_q, ns_q, st_q, run_arg_q, cand_arg;
    logic [4:0]          bit_q;
    logic                sel_q;
    logic [PMW-1:0]      min_q, run_min_q, cand_min;
    logic [N_INFO-1:0]   out_q;
    logic                dout_q, dout_vld_q, err_q;

    logic [3:0]          cnt_mem [N_CODED];
    logic [PMW-1:0]      pm_a    [N_STATE];
    logic [PMW-1:0]      pm_b    [N_STATE];
    logic [N_STATE-1:0]  dec_mem [N_STATE];

    logic                accept, last_sample, acs_dec;
    logic [6:0]          cidx;
    logic [5:0]          pred0, pred1;
    logic [PMW-1:0]      rd0, rd1, pm_in0, pm_in1, pm_new;

    always_comb begin
        accept      = bus.di_vld && (state_q == StIdle || state_q == StCollect);
        last_sample = state_q == StCollect && bus.di_vld && k_q == 7'(N_CODED - 1)
                      && rep_q == 4'(N_REP - 1);
        cidx  = {2'b00, t_q[4:0]} * 7'd3;
        pred0 = {ns_q[4:0], 1'b0};
        pred1 = {ns_q[4:0], 1'b1};
        rd0   = sel_q ? pm_b[pred0] : pm_a[pred0];
        rd1   = sel_q ? pm_b[pred1] : pm_a[pred1];
        // Stage 0 has no known start state; later stages are normalised by the last minimum.
        pm_in0 = (t_q == '0) ? '0 : rd0 - min_q;
        pm_in1 = (t_q == '0) ? '0 : rd1 - min_q;
        if (ns_q == '0 || pm_new < run_min_q) begin
            cand_min = pm_new;
            cand_arg = ns_q;
        end else begin
            cand_min = run_min_q;
            cand_arg = run_arg_q;
        end
    end

    scd_acs #(.PMW(PMW)) u_acs (
        .pm0    (pm_in0),
        .pm1    (pm_in1),
        .cnt0   (cnt_mem[cidx]),
        .cnt1   (cnt_mem[cidx + 7'd1]),
        .cnt2   (cnt_mem[cidx + 7'd2]),
        .ns     (ns_q),
        .pm_new (pm_new),
        .dec    (acs_dec)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.di_vld) state_d = StCollect;
            StCollect: begin
                if (!bus.di_vld)     state_d = StIdle;
                else if (last_sample) state_d = StAcs;
            end
            StAcs:     if (t_q == 6'd63 && ns_q == 6'd63) state_d = StTrace;
            StTrace:   if (t_q == 6'd32) state_d = StOutput;
            StOutput:  if (bit_q == 5'd31) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            rep_q      <= '0;
            t_q        <= '0;
            ns_q       <= '0;
            st_q       <= '0;
            run_arg_q  <= '0;
            run_min_q  <= '0;
            min_q      <= '0;
            sel_q      <= 1'b0;
            bit_q      <= '0;
            out_q      <= '0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= state_q == StCollect && !bus.di_vld;
            dout_vld_q <= state_q == StOutput;
            dout_q     <= state_q == StOutput && out_q[0];
            if (accept) begin
                if (k_q == 7'(N_CODED - 1)) begin
                    k_q   <= '0;
                    rep_q <= last_sample ? '0 : rep_q + 4'd1;
                end else begin
                    k_q <= k_q + 7'd1;
                end
            end else begin
                k_q   <= '0;
                rep_q <= '0;
            end
            if (state_q == StAcs) begin
                ns_q      <= ns_q + 6'd1;
                run_min_q <= cand_min;
                run_arg_q <= cand_arg;
                if (ns_q == 6'd63) begin
                    sel_q <= ~sel_q;
                    min_q <= cand_min;
                    if (t_q == 6'd63) st_q <= cand_arg;
                    // t stays at 63 so traceback starts from the last stage.
                    t_q <= (t_q == 6'd63) ? t_q : t_q + 6'd1;
                end
            end
            if (state_q == StTrace) begin
                out_q[t_q[4:0]] <= st_q[5];
                st_q            <= {st_q[4:0], dec_mem[t_q][st_q]};
                t_q             <= (t_q == 6'd32) ? '0 : t_q - 6'd1;
            end
            if (state_q == StOutput) begin
                out_q <= {1'b0, out_q[N_INFO-1:1]};
                bit_q <= bit_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) cnt_mem[k_q] <= (rep_q == '0) ? {3'b000, bus.di} : cnt_mem[k_q] + {3'b000, bus.di};
        if (state_q == StAcs) begin
            if (sel_q) pm_a[ns_q] <= pm_new;
            else       pm_b[ns_q] <= pm_new;
            dec_mem[t_q][ns_q] <= acs_dec;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != StIdle) || dout_vld_q;

endmodule

// File: tb/tb_scd.sv
// Directed bench for the signal channel decoder: clean, noisy, aborted, reset and
// back-to-back frames against a local tail-biting encoder.
module tb_scd;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scd_if bus ();

    scd #(.PMW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] INFO_A = 32'hA5C3_0F96;
    localparam logic [31:0] INFO_B = 32'h5A3C_96E1;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          first_vld_cyc = -1;
    int          err_seen = 0;
    int          overlap = 0;
    int          last_cyc = 0;
    bit          out_bits[$];
    logic [95:0]  coded;
    logic [959:0] flip;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dout_vld) begin
            if (out_bits.size() == 0) first_vld_cyc = cyc;
            out_bits.push_back(bus.dout);
        end
        if (bus.err) err_seen++;
        if (bus.err && bus.dout_vld) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tail-biting encoder written straight from the code equations.
    task automatic encode(input logic [31:0] info);
        logic [5:0] s;
        logic       d;
        s = info[31:26];
        for (int i = 0; i < 32; i++) begin
            d              = info[i];
            coded[3*i]     = d ^ s[4] ^ s[3] ^ s[1] ^ s[0];
            coded[3*i + 1] = d ^ s[5] ^ s[4] ^ s[3] ^ s[0];
            coded[3*i + 2] = d ^ s[5] ^ s[4] ^ s[2] ^ s[0];
            s              = {d, s[5:1]};
        end
    endtask

    task automatic drive(input int nsamp);
        for (int n = 0; n < nsamp; n++) begin
            @(posedge clk); #1;
            bus.di     = coded[n % 96] ^ flip[n];
            bus.di_vld = 1'b1;
            last_cyc   = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.di_vld = 1'b0;
            bus.di     = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic wait_bits(input int n);
        int guard = 0;
        while (out_bits.size() < n && guard < 5000) begin
            sample();
            guard++;
        end
    endtask

    function automatic logic [31:0] got_word(input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++)
            if (base + i < out_bits.size()) w[i] = out_bits[base + i];
        return w;
    endfunction

    task automatic run_frame(input logic [31:0] info, input string tag);
        encode(info);
        out_bits.delete();
        first_vld_cyc = -1;
        drive(960);
        idle(1);
        wait_bits(32);
        sample();
        check(tag, got_word(0), info);
        check({tag, "_count"}, out_bits.size(), 32);
    endtask

    initial begin
        bus.di     = 1'b0;
        bus.di_vld = 1'b0;
        flip       = '0;
        #12;
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_dout_vld", 32'(bus.dout_vld), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err), 0);
        rst_n = 1'b1;

        // All-zero frame: latency and busy envelope.
        encode(32'h0);
        out_bits.delete();
        first_vld_cyc = -1;
        drive(960);
        idle(1);
        wait_bits(32);
        check("zero_latency", first_vld_cyc - last_cyc, 4130);
        check("zero_bits", got_word(0), 32'h0);
        check("zero_busy_last_vld", 32'(bus.busy), 1);
        sample();
        check("zero_busy_after", 32'(bus.busy), 0);
        check("zero_vld_after", 32'(bus.dout_vld), 0);
        check("zero_count", out_bits.size(), 32);

        run_frame(INFO_A, "clean_a");
        check("clean_a_latency", first_vld_cyc - last_cyc, 4130);

        // Bit 7 wrong in 4 reps, bit 50 wrong in 3 reps.
        flip = '0;
        flip[1*96 + 7] = 1'b1; flip[3*96 + 7] = 1'b1;
        flip[5*96 + 7] = 1'b1; flip[7*96 + 7] = 1'b1;
        flip[0*96 + 50] = 1'b1; flip[4*96 + 50] = 1'b1; flip[9*96 + 50] = 1'b1;
        run_frame(INFO_A, "vote_errs");

        flip = '0;
        for (int j = 0; j < 20; j++) flip[(j*47 + 13) % 960] = 1'b1;
        run_frame(INFO_A, "spread_errs");

        // Abort at sample 500.
        flip = '0;
        encode(INFO_A);
        out_bits.delete();
        err_seen = 0;
        drive(500);
        idle(1);
        sample();
        check("abort_err_same_cycle", 32'(bus.err), 0);
        sample();
        check("abort_err_pulse", 32'(bus.err), 1);
        check("abort_busy", 32'(bus.busy), 0);
        idle(30);
        check("abort_no_vld", out_bits.size(), 0);
        check("abort_err_count", err_seen, 1);
        run_frame(INFO_B, "after_abort");

        // Reset asserted during ACS stage 20.
        encode(INFO_A);
        out_bits.delete();
        drive(960);
        idle(20*64 + 10);
        rst_n = 1'b0;
        #2;
        check("mid_rst_dout", 32'(bus.dout), 0);
        check("mid_rst_dout_vld", 32'(bus.dout_vld), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_err", 32'(bus.err), 0);
        idle(3);
        rst_n = 1'b1;
        idle(4300);
        check("mid_rst_no_vld", out_bits.size(), 0);
        check("mid_rst_busy_idle", 32'(bus.busy), 0);

        // di_vld held with junk during OUTPUT, then next frame in the first IDLE cycle.
        encode(INFO_A);
        out_bits.delete();
        drive(960);
        idle(4128);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            bus.di     = i[0];
            bus.di_vld = 1'b1;
        end
        encode(INFO_B);
        drive(960);
        idle(1);
        wait_bits(64);
        sample();
        check("b2b_first", got_word(0), INFO_A);
        check("b2b_second", got_word(32), INFO_B);
        check("b2b_count", out_bits.size(), 64);

        check("err_vld_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scd.md
# scd

Signal Channel Decoder: receive-side counterpart of the signal-segment channel encoder. It takes the 960 hard-decision samples of one signal segment, which are 10 repetitions of 96 coded bits. It combines the repetitions into per-bit vote counts, runs a serial 64-state tail-biting Viterbi decode of the rate-1/3 code, and emits the 32 recovered signal bits. It sits between the demapper and the signal-field parser.

## Interface
- `PMW`, default 10: path-metric width in bits.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `di`  in  1: hard-decision coded sample.
- `di_vld`  in  1: sample valid. The frame is 960 consecutive valid cycles.
- `do`  out  1: decoded signal bit, info bit 0 first.
- `do_vld`  out  1: decoded bit valid, 32 consecutive cycles.
- `busy`  out  1: high from the first accepted sample until the cycle after the last `do_vld`.
- `err`  out  1: one-cycle pulse when a frame is aborted.

## Operation
- Code definition: the state s[5:0] is the previous 6 info bits, s[5] newest. For input d the next state is {d, s[5:1]}. Coded outputs, emitted in order c0, c1, c2:
  - c0 = d^s4^s3^s1^s0
  - c1 = d^s5^s4^s3^s0
  - c2 = d^s5^s4^s2^s0
- Coded index k = 3·i + j for info bit i and output j. Sample n maps to k = n mod 96.
- COLLECT:
  - Count memory `cnt[0:95]`, 4 bits each, holds the number of ones across repetitions (0..10).
  - Rep 0 writes `di` directly; reps 1..9 add `di`.
  - If `di_vld` drops before sample 960: pulse `err`, discard the frame, return to IDLE.
- Branch metric for expected bit e: e ? 10−cnt : cnt. The branch metric is the sum over 3 bits, range 0..30, 5 bits.
- ACS:
  - 64 stages t = 0..63 (two wraps), using info index i = t mod 32.
  - Each stage processes next states ns = 0..63, one per cycle.
  - Predecessors are {ns[4:0], b} for b = 0, 1, and d = ns[5].
  - New metric = min(pm_old[pred] + bm), tie picks b = 0.
  - The decision bit b is stored in survivor memory `dec[t][ns]`, 64×64 bits.
- Metrics:
  - Two 64×PMW ping-pong arrays.
  - Stage 0 reads all zeros (unknown tail-biting start).
  - Each stage subtracts the previous stage's minimum on read (normalisation), so metrics never exceed 210.
  - The running minimum and argmin are tracked during each stage.
- TRACEBACK:
  - Start at the argmin state of stage 63 and step t = 63 down to 32.
  - Bit for info index t−32 is st[5]; then st ← {st[4:0], dec[t][st]}.
  - Bits are written to a 32-bit output register.
- OUTPUT: shift out bits 0..31, one per cycle.
- FSM: IDLE → COLLECT (first `di_vld`) → ACS → TRACEBACK → OUTPUT → IDLE.
- `di_vld` is ignored in every state except IDLE and COLLECT.

## Timing
- Reset values: `do`=0, `do_vld`=0, `busy`=0, `err`=0, FSM=IDLE, all counters 0. Memories are not reset.
- `busy` rises in the cycle after the first accepted sample.
- ACS starts the cycle after sample 959. It takes exactly 64 cycles per stage with no bubbles, 4096 cycles total.
- Read-modify-write of `cnt`:
  - The same address is never touched in adjacent cycles (period 96).
  - A single registered write stage is sufficient.
- TRACEBACK: 32 cycles. OUTPUT begins the next cycle.
- Fixed latency: first `do_vld` occurs 4130 cycles after the cycle carrying sample 959.
- `do_vld` is high for exactly 32 cycles. `busy` falls the cycle after.
- A new frame may start with `di_vld` in the first IDLE cycle.
- Reset assertion mid-operation: immediate return to IDLE with outputs at reset values. No partial output is produced after release.
- `err` and `do_vld` are never high together.

## Structure
- Shared package `scd_pkg` holds:
  - `N_INFO`=32, `N_CODED`=96, `N_REP`=10, `N_STATE`=64.
  - Generator masks G0=6'b011011, G1=6'b111001, G2=6'b110101, applied to s[5:0] with d always tapped.
  - The FSM state enum.
- Natural sub-module `scd_acs`: combinational branch-metric-plus-compare-select for one ns. Inputs are two predecessor metrics, three counts and ns; outputs are the new metric and the decision bit. The control FSM and memories stay in `scd`.

## Test plan
- All-zero info (coded all zero), 960 clean samples → `do` = 32 zeros, first `do_vld` 4130 cycles after the last sample.
- Info 0xA5C3_0F96 encoded tail-biting with init = last 6 bits, clean → `do` sequence equals the info bits LSB-first.
- Same frame with coded bit 7 flipped in 4 of 10 reps and bit 50 flipped in 3 reps → correct 32 bits.
- Same frame with 20 random single-bit errors spread across reps → correct 32 bits.
- `di_vld` low at sample 500 → `err` pulse, no `do_vld`; the next full frame decodes correctly.
- `rst_n` low during ACS stage 20 → all outputs 0, no `do_vld`. `di_vld` held during OUTPUT is ignored; the back-to-back next frame decodes correctly.
